ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder: a word-organised SRAM behind one data-side slave slot, decoded on HADDR[31:28].
- Sits on the data bus after the interconnect decoder and responds to NONSEQ/SEQ transfers.
- Inserts a configurable number of wait states.
- Returns the two-cycle AHB ERROR response for illegal accesses.
- Fully synchronous, single clock.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width; only 32 is supported.
- MEM_DEPTH, 1024, number of 32-bit words; must be a power of two, at most 2^26.
- WAIT_STATES, 0, wait cycles inserted before each OKAY data phase; legal range 0..15.
- SLAVE_HIT, 4'h1, required value of HADDR[31:28] (slot 0x1000_0000..0x1FFF_FFFF).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  synchronous active-low reset.
- hsel_i  in  1  slave select from the decoder.
- haddr_i  in  ADDR_WIDTH  transfer address.
- htrans_i  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite_i  in  1  1 = write.
- hsize_i  in  3  0 = byte, 1 = half, 2 = word; larger values are illegal.
- hburst_i  in  3  accepted, ignored.
- hprot_i  in  4  accepted, ignored.
- hready_i  in  1  bus-level HREADY; previous transfer complete.
- hwdata_i  in  DATA_WIDTH  write data (data phase).
- hrdata_o  out  DATA_WIDTH  read data.
- hreadyout_o  out  1  slave ready.
- hresp_o  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - state=IDLE, hreadyout_o=1, hresp_o=0, hrdata_o=0, wait counter=0, captured address-phase regs cleared.
  - SRAM contents are NOT reset.
  - Reset asserted mid wait or mid error aborts the transfer; a pending write is discarded.
- Address phase accept: hsel_i & hready_i & htrans_i[1]. Capture haddr, hwrite, hsize.
- IDLE/BUSY or unselected while hready_i=1: no access. The slave stays in or returns to IDLE with OKAY, zero wait.
- Error check at accept. ERROR if any of:
  - haddr_i[31:28] != SLAVE_HIT;
  - word index haddr_i[27:2] >= MEM_DEPTH;
  - hsize_i > 2;
  - misalignment: half with haddr_i[0]=1, or word with haddr_i[1:0] != 0.
- States:
  - IDLE: hreadyout_o=1, hresp_o=0.
  - WAIT: hreadyout_o=0, hresp_o=0; counter counts WAIT_STATES cycles, then -> DATA.
  - DATA: hreadyout_o=1, hresp_o=0; transfer completes this cycle.
  - ERR1: hreadyout_o=0, hresp_o=1; always -> ERR2.
  - ERR2: hreadyout_o=1, hresp_o=1.
- Transitions from IDLE, DATA and ERR2 (the states with hreadyout_o=1):
  - on a legal accept: -> WAIT if WAIT_STATES>0, else -> DATA;
  - on an illegal accept: -> ERR1;
  - with no accept: -> IDLE.
  - This gives back-to-back pipelined transfers.
- Latency:
  - OKAY transfer: data phase lasts WAIT_STATES+1 cycles.
  - ERROR transfer: always exactly 2 cycles, regardless of WAIT_STATES.
- Write:
  - hwdata_i is sampled on the DATA-state clock edge only.
  - Byte lanes come from the captured size and addr[1:0] (little-endian):
    - byte: lane addr[1:0];
    - half: lanes {addr[1],0} and {addr[1],1};
    - word: all four lanes.
  - Other bytes are unchanged.
  - An erroring write never modifies memory.
- Read:
  - In DATA, hrdata_o = mem[captured index], full word, all lanes driven.
  - Outside a read DATA cycle, hrdata_o=0.
- Write followed immediately by a read of the same word returns the newly written data: the write commits at the end of DATA, before the read's data phase.
- During WAIT/ERR1, hready_i is low bus-wide, so no new address is accepted. Any hsel/htrans activity in these states is ignored.
- Captured address regs hold stable for the whole data phase.

Test Plan:
- Reset, then idle -> hreadyout_o=1, hresp_o=0, hrdata_o=0.
- WAIT_STATES=0:
  - write word 0xDEADBEEF @0x1000_0010, then read @0x1000_0010 back-to-back -> read data phase returns 0xDEADBEEF in 1 cycle, no stall.
  - byte write 0xAA @0x1000_0013 over 0xDEADBEEF, then word read -> 0xAAADBEEF.
  - half write 0x1234 @0x1000_0012 over 0xAAADBEEF, then word read -> 0x1234BEEF.
- WAIT_STATES=3: read @0x1000_0010 -> hreadyout_o low for exactly 3 cycles, high on the 4th with data and hresp_o=0.
- Errors: access @0x2000_0000, word @0x1000_0002, hsize=3, and index=MEM_DEPTH -> each gives cycle 1 {hreadyout_o=0, hresp_o=1} and cycle 2 {1,1}; target memory unchanged on later readback.
- Reset pulsed during the 2nd wait cycle of a write of 0x5555_5555 @0x1000_0020 (old 0x0) -> outputs return to reset values next cycle; readback = 0x0.
- Interleave NONSEQ, BUSY, IDLE and hsel_i=0 cycles -> only the NONSEQ access takes effect; BUSY/IDLE cycles show OKAY with zero wait.

Source files
------------

// File: rtl/ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_sram_slave
//
// AHB-Lite responder for a word-organised SRAM in one data-side slave slot.
// The slot is decoded on HADDR[31:28] against SLAVE_HIT. Legal transfers get
// WAIT_STATES stall cycles followed by a one-cycle OKAY data phase. Illegal
// transfers get the two-cycle AHB ERROR response and never touch memory.
// Transfers are pipelined back to back from IDLE, DATA and ERR2.
//
// Parameters:
//   ADDR_WIDTH  - HADDR width (32)
//   DATA_WIDTH  - HWDATA/HRDATA width (only 32 is supported)
//   MEM_DEPTH   - number of 32-bit words, power of two, at most 2^26
//   WAIT_STATES - stall cycles before each OKAY data phase, 0..15
//   SLAVE_HIT   - required value of HADDR[31:28]
//
// Ports:
//   clk_i       in   system clock
//   rst_ni      in   synchronous active-low reset
//   hsel_i      in   slave select from the decoder
//   haddr_i     in   transfer address
//   htrans_i    in   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
//   hwrite_i    in   1 = write
//   hsize_i     in   0 = byte, 1 = half, 2 = word; larger is illegal
//   hburst_i    in   accepted, ignored
//   hprot_i     in   accepted, ignored
//   hready_i    in   bus-level HREADY
//   hwdata_i    in   write data (data phase)
//   hrdata_o    out  read data, zero outside a read data phase
//   hreadyout_o out  slave ready
//   hresp_o     out  0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
module ahb_lite_sram_slave #(
  parameter int         ADDR_WIDTH  = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter int         MEM_DEPTH   = 1024,
  parameter int         WAIT_STATES = 0,
  parameter logic [3:0] SLAVE_HIT   = 4'h1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [3:0]            hprot_i,
  input  logic                  hready_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hreadyout_o,
  output logic                  hresp_o
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // States
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  // The counter is loaded with WAIT_STATES-1 so that WAIT lasts exactly
  // WAIT_STATES cycles, leaving through DATA when it reaches zero.
  localparam bit         HAS_WAIT   = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [26:0] DEPTH_LIM = 27'(MEM_DEPTH);

  logic [2:0]            r_state;
  logic [2:0]            w_nextState;
  logic [3:0]            r_waitCnt;
  logic [IDX_W-1:0]      r_idx;
  logic [1:0]            r_lowAddr;
  logic                  r_write;
  logic [2:0]            r_size;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_readyState;
  logic                  w_accept;
  logic                  w_hitErr;
  logic                  w_rangeErr;
  logic                  w_sizeErr;
  logic                  w_alignErr;
  logic                  w_illegal;
  logic [3:0]            w_laneEn;
  logic                  w_unused;

  // hburst/hprot carry no meaning for a plain SRAM.
  assign w_unused = ^{hburst_i, hprot_i};

  // A new address phase can only be taken while this slave shows ready;
  // in WAIT and ERR1 the bus is stalled and any activity is ignored.
  assign w_readyState = (r_state == ST_IDLE) || (r_state == ST_DATA) ||
                        (r_state == ST_ERR2);
  assign w_accept     = w_readyState && hsel_i && hready_i && htrans_i[1];

  // The word index is zero-extended so that an index equal to MEM_DEPTH is
  // caught even when MEM_DEPTH is the full 2^26.
  assign w_hitErr   = (haddr_i[31:28] != SLAVE_HIT);
  assign w_rangeErr = ({1'b0, haddr_i[27:2]} >= DEPTH_LIM);
  assign w_sizeErr  = (hsize_i > 3'd2);
  assign w_alignErr = ((hsize_i == 3'd1) && haddr_i[0]) ||
                      ((hsize_i == 3'd2) && (haddr_i[1:0] != 2'b00));
  assign w_illegal  = w_hitErr || w_rangeErr || w_sizeErr || w_alignErr;

  // Next-state selection; the ready states all share the same accept logic,
  // which is what allows pipelined back-to-back transfers.
  always_comb begin
    w_nextState = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (w_accept) begin
          if (w_illegal) begin
            w_nextState = ST_ERR1;
          end else if (HAS_WAIT) begin
            w_nextState = ST_WAIT;
          end else begin
            w_nextState = ST_DATA;
          end
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_nextState = (r_waitCnt == 4'd0) ? ST_DATA : ST_WAIT;
      end
      ST_ERR1: begin
        w_nextState = ST_ERR2;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State, wait counter and captured address phase. The captured registers
  // change only on an accept, so they hold for the whole data phase.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_waitCnt <= 4'd0;
      r_idx     <= '0;
      r_lowAddr <= 2'b00;
      r_write   <= 1'b0;
      r_size    <= 3'd0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_idx     <= haddr_i[IDX_W+1:2];
        r_lowAddr <= haddr_i[1:0];
        r_write   <= hwrite_i;
        r_size    <= hsize_i;
      end
      if (w_accept && !w_illegal) begin
        r_waitCnt <= WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_waitCnt != 4'd0)) begin
        r_waitCnt <= r_waitCnt - 4'd1;
      end
    end
  end

  // Little-endian byte lanes from the captured size and low address bits.
  always_comb begin
    w_laneEn = 4'b0000;
    case (r_size)
      3'd0:    w_laneEn = 4'b0001 << r_lowAddr;
      3'd1:    w_laneEn = r_lowAddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    w_laneEn = 4'b1111;
      default: w_laneEn = 4'b0000;
    endcase
  end

  // SRAM write port. Memory is not reset, but a reset landing on the DATA
  // edge still discards the write. Only DATA of a legal write reaches here,
  // so erroring writes never modify memory.
  always_ff @(posedge clk_i) begin
    if (rst_ni && (r_state == ST_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_laneEn[b]) begin
          r_mem[r_idx][8*b +: 8] <= hwdata_i[8*b +: 8];
        end
      end
    end
  end

  // The read is combinational from the captured index, so a read directly
  // after a write to the same word sees the value committed on the write's
  // DATA edge.
  assign hrdata_o    = ((r_state == ST_DATA) && !r_write) ? r_mem[r_idx] : '0;
  assign hreadyout_o = (r_state != ST_WAIT) && (r_state != ST_ERR1);
  assign hresp_o     = (r_state == ST_ERR1) || (r_state == ST_ERR2);

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_sram_slave
//
// Drives two instances of ahb_lite_sram_slave (WAIT_STATES=0 and 3) from one
// shared bus master; only the selected instance gets hsel. Each instance's
// hready_i is its own hreadyout_o (single-slave bus). Transfers come from
// vector tables; accepted transfers push their expected data phase into a
// scoreboard queue, and a negedge monitor pops and checks every cycle.
// ---------------------------------------------------------------------------
module tb_ahb_lite_sram_slave;

  localparam int MEM_DEPTH = 1024;

  typedef struct {
    int          id;
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRdata;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;

  int          activeDut;
  logic        hsel0, hsel3;
  logic        ready0, ready3, resp0, resp3;
  logic [31:0] rdata0, rdata3;
  logic        obsReady, obsResp;
  logic [31:0] obsRdata;

  int          errors;
  int          checks;

  vec_t        sbQ[$];
  vec_t        cur;
  bit          curValid;
  int          curCycle;
  bit          monEnable;
  logic [31:0] dataPhaseWdata;

  logic        expReady, expResp;
  logic [31:0] expData;
  string       monName;

  vec_t        tab0[$];
  vec_t        tab3[$];
  vec_t        tabPost[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign hsel0    = hsel && (activeDut == 0);
  assign hsel3    = hsel && (activeDut == 3);
  assign obsReady = (activeDut == 3) ? ready3 : ready0;
  assign obsResp  = (activeDut == 3) ? resp3  : resp0;
  assign obsRdata = (activeDut == 3) ? rdata3 : rdata0;

  ahb_lite_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(MEM_DEPTH),
    .WAIT_STATES(0), .SLAVE_HIT(4'h1)
  ) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .hsel_i(hsel0), .haddr_i(haddr),
    .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize),
    .hburst_i(hburst), .hprot_i(hprot), .hready_i(ready0),
    .hwdata_i(hwdata), .hrdata_o(rdata0), .hreadyout_o(ready0),
    .hresp_o(resp0)
  );

  ahb_lite_sram_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(MEM_DEPTH),
    .WAIT_STATES(3), .SLAVE_HIT(4'h1)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .hsel_i(hsel3), .haddr_i(haddr),
    .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize),
    .hburst_i(hburst), .hprot_i(hprot), .hready_i(ready3),
    .hwdata_i(hwdata), .hrdata_o(rdata3), .hreadyout_o(ready3),
    .hresp_o(resp3)
  );

  function automatic vec_t mk(input int id, input logic sel,
                              input logic [1:0] tr, input logic [31:0] a,
                              input logic w, input logic [2:0] sz,
                              input logic [31:0] wd, input logic er,
                              input logic [31:0] rd);
    vec_t v;
    v.id = id; v.sel = sel; v.trans = tr; v.addr = a; v.write = w;
    v.size = sz; v.wdata = wd; v.expErr = er; v.expRdata = rd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic gotReady,
                             input logic gotResp, input logic [31:0] gotData,
                             input logic wantReady, input logic wantResp,
                             input logic [31:0] wantData);
    checks++;
    if ({gotReady, gotResp, gotData} !== {wantReady, wantResp, wantData}) begin
      errors++;
      $display("[TB] FAIL %s: got ready=%0b resp=%0b rdata=%08h, expected ready=%0b resp=%0b rdata=%08h",
               name, gotReady, gotResp, gotData, wantReady, wantResp, wantData);
    end
  endtask

  // Called 2 time units after a posedge; returns at the same phase.
  task automatic applyStimulus(input vec_t v);
    int  n;
    bit  accepted;
    hsel   = v.sel;
    haddr  = v.addr;
    htrans = v.trans;
    hwrite = v.write;
    hsize  = v.size;
    hwdata = dataPhaseWdata;
    if (v.sel && v.trans[1]) begin
      sbQ.push_back(v);
      n = 0;
      accepted = 1'b0;
      while (!accepted && n < 64) begin
        @(negedge clk);
        accepted = obsReady;
        @(posedge clk);
        #2;
        n++;
      end
      if (!accepted) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout xfer%0d: got hreadyout low for %0d cycles, expected acceptance", v.id, n);
      end else begin
        dataPhaseWdata = v.wdata;
      end
    end else begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idleCycles(input int n);
    hsel   = 1'b0;
    htrans = 2'd0;
    hwdata = dataPhaseWdata;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkDrain(input string name);
    int pending;
    pending = sbQ.size() + (curValid ? 1 : 0);
    checks++;
    if (pending != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d transfers still pending, expected 0", name, pending);
    end
  endtask

  // Every cycle: compare outputs against the data phase in progress (or the
  // idle response), then start a new data phase if this cycle's address
  // phase will be accepted on the coming edge.
  always @(negedge clk) begin
    if (monEnable) begin
      expReady = 1'b1;
      expResp  = 1'b0;
      expData  = 32'h0;
      monName  = "idle";
      if (curValid) begin
        monName = $sformatf("xfer%0d_c%0d", cur.id, curCycle);
        if (cur.expErr) begin
          expResp  = 1'b1;
          expReady = (curCycle == 1);
        end else begin
          expReady = (curCycle == ((activeDut == 3) ? 3 : 0));
          if (expReady && !cur.write) expData = cur.expRdata;
        end
      end
      checkOutput(monName, obsReady, obsResp, obsRdata, expReady, expResp, expData);
      if (curValid) begin
        if (expReady) curValid = 1'b0;
        else curCycle++;
      end
      if (hsel && htrans[1] && obsReady) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept: got an accept with empty scoreboard, expected none");
        end else begin
          cur      = sbQ.pop_front();
          curValid = 1'b1;
          curCycle = 0;
        end
      end
    end
  end

  initial begin
    errors = 0; checks = 0;
    curValid = 1'b0; curCycle = 0; monEnable = 1'b0;
    dataPhaseWdata = 32'h0;
    activeDut = 0;
    rst_n = 1'b0;
    hsel = 1'b0; haddr = 32'h0; htrans = 2'd0; hwrite = 1'b0;
    hsize = 3'd0; hburst = 3'd0; hprot = 4'b0011; hwdata = 32'h0;

    // WAIT_STATES=0 vectors: id, sel, trans, addr, write, size, wdata, err, rdata
    tab0.push_back(mk( 1, 1, 2'd2, 32'h1000_0000, 1, 3'd2, 32'h1111_1111, 0, 32'h0));
    tab0.push_back(mk( 2, 1, 2'd2, 32'h1000_0010, 1, 3'd2, 32'hDEAD_BEEF, 0, 32'h0));
    tab0.push_back(mk( 3, 1, 2'd2, 32'h1000_0010, 0, 3'd2, 32'h0,         0, 32'hDEAD_BEEF));
    tab0.push_back(mk( 4, 1, 2'd2, 32'h1000_0013, 1, 3'd0, 32'hAA12_3456, 0, 32'h0));
    tab0.push_back(mk( 5, 1, 2'd2, 32'h1000_0010, 0, 3'd2, 32'h0,         0, 32'hAAAD_BEEF));
    tab0.push_back(mk( 6, 1, 2'd2, 32'h1000_0012, 1, 3'd1, 32'h1234_9876, 0, 32'h0));
    tab0.push_back(mk( 7, 1, 2'd2, 32'h1000_0010, 0, 3'd2, 32'h0,         0, 32'h1234_BEEF));
    tab0.push_back(mk( 8, 1, 2'd2, 32'h1000_0011, 1, 3'd0, 32'h0000_C300, 0, 32'h0));
    tab0.push_back(mk( 9, 1, 2'd3, 32'h1000_0010, 0, 3'd2, 32'h0,         0, 32'h1234_C3EF));
    tab0.push_back(mk(10, 1, 2'd2, 32'h1000_0000, 1, 3'd1, 32'hFFFF_7777, 0, 32'h0));
    tab0.push_back(mk(11, 1, 2'd2, 32'h2000_0000, 1, 3'd2, 32'hBADB_AD00, 1, 32'h0));
    tab0.push_back(mk(12, 1, 2'd2, 32'h1000_0002, 1, 3'd2, 32'hBAD0_BAD0, 1, 32'h0));
    tab0.push_back(mk(13, 1, 2'd2, 32'h1000_0010, 1, 3'd3, 32'hFFFF_FFFF, 1, 32'h0));
    tab0.push_back(mk(14, 1, 2'd2, 32'h1000_1000, 1, 3'd2, 32'hEEEE_EEEE, 1, 32'h0));
    tab0.push_back(mk(15, 1, 2'd2, 32'h1000_0011, 1, 3'd1, 32'hDDDD_DDDD, 1, 32'h0));
    tab0.push_back(mk(16, 1, 2'd2, 32'h0000_0010, 0, 3'd2, 32'h0,         1, 32'h0));
    tab0.push_back(mk(17, 1, 2'd2, 32'h1000_0000, 0, 3'd2, 32'h0,         0, 32'h1111_7777));
    tab0.push_back(mk(18, 1, 2'd2, 32'h1000_0010, 0, 3'd2, 32'h0,         0, 32'h1234_C3EF));
    tab0.push_back(mk(19, 1, 2'd2, 32'h1000_0008, 1, 3'd2, 32'h8888_8888, 0, 32'h0));
    tab0.push_back(mk(20, 1, 2'd2, 32'h1000_0004, 1, 3'd2, 32'h4444_4444, 0, 32'h0));
    tab0.push_back(mk(21, 1, 2'd1, 32'h1000_0008, 1, 3'd2, 32'h4444_4444, 0, 32'h0));
    tab0.push_back(mk(22, 1, 2'd0, 32'h1000_0008, 1, 3'd2, 32'h4444_4444, 0, 32'h0));
    tab0.push_back(mk(23, 0, 2'd2, 32'h1000_0008, 1, 3'd2, 32'h4444_4444, 0, 32'h0));
    tab0.push_back(mk(24, 1, 2'd1, 32'h1000_0004, 0, 3'd2, 32'h0,         0, 32'h0));
    tab0.push_back(mk(25, 1, 2'd2, 32'h1000_0008, 0, 3'd2, 32'h0,         0, 32'h8888_8888));
    tab0.push_back(mk(26, 1, 2'd2, 32'h1000_0004, 0, 3'd2, 32'h0,         0, 32'h4444_4444));

    // WAIT_STATES=3 vectors
    tab3.push_back(mk(31, 1, 2'd2, 32'h1000_0010, 1, 3'd2, 32'hCAFE_F00D, 0, 32'h0));
    tab3.push_back(mk(32, 1, 2'd2, 32'h1000_0010, 0, 3'd2, 32'h0,         0, 32'hCAFE_F00D));
    tab3.push_back(mk(33, 1, 2'd2, 32'h2000_0000, 0, 3'd2, 32'h0,         1, 32'h0));
    tab3.push_back(mk(34, 1, 2'd2, 32'h1000_0020, 1, 3'd2, 32'h0000_0000, 0, 32'h0));
    tab3.push_back(mk(35, 1, 2'd2, 32'h1000_0020, 0, 3'd2, 32'h0,         0, 32'h0000_0000));

    // Readback after the aborted write
    tabPost.push_back(mk(41, 1, 2'd2, 32'h1000_0020, 0, 3'd2, 32'h0, 0, 32'h0000_0000));

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_ws0", ready0, resp0, rdata0, 1'b1, 1'b0, 32'h0);
    checkOutput("reset_ws3", ready3, resp3, rdata3, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #2;

    monEnable = 1'b1;
    foreach (tab0[i]) applyStimulus(tab0[i]);
    idleCycles(4);
    checkDrain("drain_ws0");

    activeDut = 3;
    foreach (tab3[i]) applyStimulus(tab3[i]);
    idleCycles(6);
    checkDrain("drain_ws3");

    // Reset during the second wait cycle of a write to 0x1000_0020.
    monEnable = 1'b0;
    hsel = 1'b1; haddr = 32'h1000_0020; htrans = 2'd2; hwrite = 1'b1;
    hsize = 3'd2; hwdata = dataPhaseWdata;
    @(posedge clk);
    #2;
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h5555_5555;
    dataPhaseWdata = 32'h5555_5555;
    @(negedge clk);
    checkOutput("rst_wait1", ready3, resp3, rdata3, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    @(negedge clk);
    checkOutput("rst_wait2", ready3, resp3, rdata3, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_abort", ready3, resp3, rdata3, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    sbQ.delete();
    curValid = 1'b0;
    monEnable = 1'b1;
    idleCycles(6);
    foreach (tabPost[i]) applyStimulus(tabPost[i]);
    idleCycles(6);
    checkDrain("drain_post");

    monEnable = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
